// File: rtl/m_axi_reader.sv
`default_nettype none
// ============================================================================
// Module   : m_axi_reader
// Purpose  : Issues a single AXI4 INCR read burst of 1..BUF_DEPTH beats and
//            stores the returned R beats in a local buffer that can be read
//            back through a registered read port.
// Ports    : clk, areset (async, active low)
//            start_i/addr_i/len_i        - request (len_i = beat count)
//            ar*_o, arready_i            - AXI read address channel
//            r*_i, rready_o              - AXI read data channel
//            buf_addr_i/buf_data_o       - buffer read port (1-cycle latency)
//            status_o/busy_o/done_o/err_o- state code and completion flags
// Revision : 1.0 - initial release
// ============================================================================
module m_axi_reader #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 64,
    parameter int BUF_DEPTH  = 16,
    localparam int BUF_AW    = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1
) (
    input  logic                  clk,
    input  logic                  areset,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [8:0]            len_i,
    output logic [3:0]            arid_o,
    output logic [ADDR_WIDTH-1:0] araddr_o,
    output logic [7:0]            arlen_o,
    output logic [2:0]            arsize_o,
    output logic [1:0]            arburst_o,
    output logic                  arvalid_o,
    input  logic                  arready_i,
    input  logic [3:0]            rid_i,
    input  logic [DATA_WIDTH-1:0] rdata_i,
    input  logic [1:0]            rresp_i,
    input  logic                  rlast_i,
    input  logic                  rvalid_i,
    output logic                  rready_o,
    input  logic [BUF_AW-1:0]     buf_addr_i,
    output logic [DATA_WIDTH-1:0] buf_data_o,
    output logic [2:0]            status_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o
);

    localparam logic [2:0] C_ARSIZE = 3'($clog2(DATA_WIDTH / 8));
    localparam logic [8:0] C_DEPTH  = 9'(BUF_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ADDR  = 3'd1,
        S_DATA  = 3'd2,
        S_DONE  = 3'd3,
        S_ERROR = 3'd4
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [7:0]              arlen_q, arlen_d;
    logic [2:0]              arsize_q, arsize_d;
    logic [1:0]              arburst_q, arburst_d;
    logic [8:0]              beat_q, beat_d;     // beats accepted so far
    logic                    berr_q, berr_d;     // error seen in current burst
    logic                    err_q, err_d;
    logic [DATA_WIDTH-1:0]   buf_data_q;
    logic [DATA_WIDTH-1:0]   mem [BUF_DEPTH];

    logic                    len_ok;
    logic                    is_len_beat;
    logic                    beat_err;
    logic                    wr_en;

    assign len_ok      = (len_i != 9'd0) && (len_i <= C_DEPTH);
    assign is_len_beat = (beat_q == {1'b0, arlen_q});
    // Any protocol or response problem on this beat; rlast must coincide
    // exactly with the len-th beat.
    assign beat_err    = (rresp_i != 2'b00) || (rid_i != 4'd0) ||
                         (rlast_i != is_len_beat);
    // Beats past the end of the buffer (missing rlast) are dropped, not wrapped.
    assign wr_en       = (state_q == S_DATA) && rvalid_i && (beat_q < C_DEPTH);

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        arlen_d   = arlen_q;
        arsize_d  = arsize_q;
        arburst_d = arburst_q;
        beat_d    = beat_q;
        berr_d    = berr_q;
        err_d     = err_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    if (len_ok) begin
                        addr_d    = addr_i;
                        arlen_d   = 8'(len_i - 9'd1);
                        arsize_d  = C_ARSIZE;
                        arburst_d = 2'b01;
                        beat_d    = 9'd0;
                        berr_d    = 1'b0;
                        err_d     = 1'b0;
                        state_d   = S_ADDR;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_ERROR;
                    end
                end
            end
            S_ADDR: begin
                if (arready_i) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (rvalid_i) begin
                    // Saturate so a runaway burst never aliases onto len-1.
                    if (beat_q != 9'h1FF) begin
                        beat_d = beat_q + 9'd1;
                    end
                    berr_d = berr_q | beat_err;
                    if (rlast_i) begin
                        if (berr_q || beat_err) begin
                            err_d   = 1'b1;
                            state_d = S_ERROR;
                        end else begin
                            state_d = S_DONE;
                        end
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERROR: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            arlen_q    <= '0;
            arsize_q   <= '0;
            arburst_q  <= '0;
            beat_q     <= '0;
            berr_q     <= 1'b0;
            err_q      <= 1'b0;
            buf_data_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            arlen_q    <= arlen_d;
            arsize_q   <= arsize_d;
            arburst_q  <= arburst_d;
            beat_q     <= beat_d;
            berr_q     <= berr_d;
            err_q      <= err_d;
            buf_data_q <= mem[buf_addr_i];
        end
    end

    // Buffer storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[beat_q[BUF_AW-1:0]] <= rdata_i;
        end
    end

    assign arid_o     = 4'd0;
    assign araddr_o   = addr_q;
    assign arlen_o    = arlen_q;
    assign arsize_o   = arsize_q;
    assign arburst_o  = arburst_q;
    assign arvalid_o  = (state_q == S_ADDR);
    assign rready_o   = (state_q == S_DATA);
    assign buf_data_o = buf_data_q;
    assign status_o   = state_q;
    assign busy_o     = (state_q == S_ADDR) || (state_q == S_DATA);
    assign done_o     = (state_q == S_DONE) || (state_q == S_ERROR);
    assign err_o      = err_q;

endmodule
`default_nettype wire

// File: tb/tb_m_axi_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_m_axi_reader
// Purpose  : Self-checking bench for m_axi_reader. A behavioural model keeps
//            the expected buffer image and error flag; randomized bursts are
//            compared against it.
// Revision : 1.0 - initial release
// ============================================================================
module tb_m_axi_reader;

    localparam int DW  = 32;
    localparam int AW  = 64;
    localparam int BD  = 16;
    localparam int BAW = 4;

    logic           clk = 1'b0;
    logic           areset = 1'b0;
    logic           start_i = 1'b0;
    logic [AW-1:0]  addr_i = '0;
    logic [8:0]     len_i = '0;
    logic [3:0]     arid_o;
    logic [AW-1:0]  araddr_o;
    logic [7:0]     arlen_o;
    logic [2:0]     arsize_o;
    logic [1:0]     arburst_o;
    logic           arvalid_o;
    logic           arready_i = 1'b0;
    logic [3:0]     rid_i = '0;
    logic [DW-1:0]  rdata_i = '0;
    logic [1:0]     rresp_i = '0;
    logic           rlast_i = 1'b0;
    logic           rvalid_i = 1'b0;
    logic           rready_o;
    logic [BAW-1:0] buf_addr_i = '0;
    logic [DW-1:0]  buf_data_o;
    logic [2:0]     status_o;
    logic           busy_o;
    logic           done_o;
    logic           err_o;

    m_axi_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BUF_DEPTH(BD)) dut (
        .clk(clk), .areset(areset),
        .start_i(start_i), .addr_i(addr_i), .len_i(len_i),
        .arid_o(arid_o), .araddr_o(araddr_o), .arlen_o(arlen_o),
        .arsize_o(arsize_o), .arburst_o(arburst_o),
        .arvalid_o(arvalid_o), .arready_i(arready_i),
        .rid_i(rid_i), .rdata_i(rdata_i), .rresp_i(rresp_i),
        .rlast_i(rlast_i), .rvalid_i(rvalid_i), .rready_o(rready_o),
        .buf_addr_i(buf_addr_i), .buf_data_o(buf_data_o),
        .status_o(status_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] mdl_mem [BD];
    bit          mdl_known [BD];
    bit          mdl_err = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        check("ar_r_exclusive", 64'(arvalid_o & rready_o), 64'd0);
    endtask

    task automatic expect_state(input string tag, input int st, input bit dn, input bit er);
        check({tag, "_status"}, 64'(status_o), 64'(st));
        check({tag, "_busy"},   64'(busy_o),   64'(st == 1 || st == 2));
        check({tag, "_done"},   64'(done_o),   64'(dn));
        check({tag, "_err"},    64'(err_o),    64'(er));
        check({tag, "_arvld"},  64'(arvalid_o), 64'(st == 1));
        check({tag, "_rrdy"},   64'(rready_o),  64'(st == 2));
    endtask

    task automatic check_reset_outs(input string tag);
        expect_state(tag, 0, 1'b0, 1'b0);
        check({tag, "_araddr"},  araddr_o,          64'd0);
        check({tag, "_arlen"},   64'(arlen_o),      64'd0);
        check({tag, "_arsize"},  64'(arsize_o),     64'd0);
        check({tag, "_arburst"}, 64'(arburst_o),    64'd0);
        check({tag, "_arid"},    64'(arid_o),       64'd0);
        check({tag, "_bufdata"}, 64'(buf_data_o),   64'd0);
    endtask

    task automatic readback();
        for (int i = 0; i < BD; i++) begin
            buf_addr_i = BAW'(i);
            tick();
            if (mdl_known[i]) check("buf_readback", 64'(buf_data_o), 64'(mdl_mem[i]));
            check("err_sticky", 64'(err_o), 64'(mdl_err));
        end
    endtask

    // One complete request. rlast_pos is the 0-based beat carrying rlast;
    // resp_beat / rid_beat (-1 = none) pick a beat with a bad RRESP / RID.
    task automatic run_burst(input logic [63:0] addr, input int len, input int rlast_pos,
                             input int resp_beat, input int rid_beat, input int ar_delay,
                             input int min_gap, input int max_gap, input bit poke_start,
                             input bit seq_data);
        bit          exp_err;
        int          nb;
        logic [31:0] old;
        bit          oldk;
        start_i = 1'b1; addr_i = addr; len_i = 9'(len);
        tick();
        start_i = 1'b0;
        if (len < 1 || len > BD) begin
            mdl_err = 1'b1;
            expect_state("badlen", 4, 1'b1, 1'b1);
            tick();
            expect_state("badlen_idle", 0, 1'b0, 1'b1);
            return;
        end
        expect_state("addr", 1, 1'b0, 1'b0);
        check("araddr",  araddr_o,          addr);
        check("arlen",   64'(arlen_o),      64'(len - 1));
        check("arsize",  64'(arsize_o),     64'd2);
        check("arburst", 64'(arburst_o),    64'd1);
        check("arid",    64'(arid_o),       64'd0);
        for (int i = 0; i < ar_delay; i++) begin
            tick();
            expect_state("addr_wait", 1, 1'b0, 1'b0);
            check("araddr_stable", araddr_o,     addr);
            check("arlen_stable",  64'(arlen_o), 64'(len - 1));
        end
        arready_i = 1'b1;
        tick();
        arready_i = 1'b0;
        expect_state("data", 2, 1'b0, 1'b0);
        exp_err = (rlast_pos != len - 1);
        nb = rlast_pos + 1;
        for (int b = 0; b < nb; b++) begin
            int gaps = int'($urandom_range(max_gap, min_gap));
            for (int g = 0; g < gaps; g++) begin
                if (poke_start) begin
                    start_i = 1'b1;
                    addr_i  = {$urandom, $urandom};
                    len_i   = 9'($urandom_range(20, 0));
                end
                tick();
                start_i = 1'b0;
                expect_state("gap", 2, 1'b0, 1'b0);
            end
            rvalid_i   = 1'b1;
            rdata_i    = seq_data ? 32'(32'h11 + b) : $urandom;
            rresp_i    = (b == resp_beat) ? 2'b10 : 2'b00;
            rid_i      = (b == rid_beat) ? 4'($urandom_range(15, 1)) : 4'd0;
            rlast_i    = (b == rlast_pos);
            buf_addr_i = BAW'(b % BD);
            if (b == resp_beat || b == rid_beat) exp_err = 1'b1;
            old  = mdl_mem[b % BD];
            oldk = mdl_known[b % BD];
            if (b < BD) begin
                mdl_mem[b]   = rdata_i;
                mdl_known[b] = 1'b1;
            end
            tick();
            rvalid_i = 1'b0;
            rlast_i  = 1'b0;
            rresp_i  = 2'b00;
            rid_i    = 4'd0;
            if (oldk) check("read_during_write", 64'(buf_data_o), 64'(old));
            if (b < nb - 1) expect_state("beat", 2, 1'b0, 1'b0);
        end
        mdl_err = exp_err;
        expect_state("end", exp_err ? 4 : 3, 1'b1, exp_err);
        tick();
        expect_state("idle", 0, 1'b0, exp_err);
    endtask

    initial begin
        for (int i = 0; i < BD; i++) mdl_known[i] = 1'b0;

        // Reset values while areset is held low.
        #1;
        check_reset_outs("reset");
        repeat (3) @(negedge clk);
        areset = 1'b1;

        // Directed: first burst right after reset release, 0x11..0x14.
        run_burst(64'hA3DD_0000, 4, 3, -1, -1, 3, 0, 0, 1'b0, 1'b1);
        readback();
        // rvalid every other cycle.
        run_burst(64'h1000, 4, 3, -1, -1, 0, 1, 1, 1'b0, 1'b1);
        readback();
        // Fill the whole buffer.
        run_burst(64'h2000, BD, BD - 1, -1, -1, 1, 0, 1, 1'b0, 1'b0);
        readback();
        // Illegal lengths.
        run_burst(64'h3000, 0, 0, -1, -1, 0, 0, 0, 1'b0, 1'b0);
        run_burst(64'h3000, BD + 1, 0, -1, -1, 0, 0, 0, 1'b0, 1'b0);
        // Error response on beat 2, then early rlast on beat 3.
        run_burst(64'h4000, 4, 3, 1, -1, 0, 0, 0, 1'b0, 1'b0);
        readback();
        run_burst(64'h4100, 4, 2, -1, -1, 0, 0, 0, 1'b0, 1'b0);
        readback();
        // start_i pulses during DATA are ignored.
        run_burst(64'h5000, 6, 5, -1, -1, 1, 1, 2, 1'b1, 1'b0);
        readback();
        // Missing rlast beyond the buffer end.
        run_burst(64'h6000, BD, BD + 2, -1, -1, 0, 0, 0, 1'b0, 1'b0);
        readback();

        // Randomized bursts.
        for (int k = 0; k < 25; k++) begin
            int len  = int'($urandom_range(BD + 1, 0));
            int mode = int'($urandom_range(5, 0));
            int rlp  = (len > 0) ? len - 1 : 0;
            int rsb  = -1;
            int rib  = -1;
            if (len >= 1 && len <= BD) begin
                if (mode == 4 && len > 1) rlp = int'($urandom_range(len - 2, 0));
                if (mode == 5) rlp = len - 1 + int'($urandom_range(3, 1));
                if (mode == 2) rsb = int'($urandom_range(rlp, 0));
                if (mode == 3) rib = int'($urandom_range(rlp, 0));
            end
            run_burst({$urandom, $urandom}, len, rlp, rsb, rib,
                      int'($urandom_range(3, 0)), 0, int'($urandom_range(2, 0)),
                      1'($urandom_range(1, 0)), 1'b0);
            readback();
        end

        // Reset in the middle of beat 2 of 4.
        start_i = 1'b1; addr_i = 64'h7000; len_i = 9'd4;
        tick();
        start_i = 1'b0;
        arready_i = 1'b1;
        tick();
        arready_i = 1'b0;
        expect_state("rst_data", 2, 1'b0, 1'b0);
        rvalid_i = 1'b1; rdata_i = 32'hCAFE_0001; buf_addr_i = '0;
        mdl_mem[0] = rdata_i; mdl_known[0] = 1'b1;
        tick();
        rdata_i = 32'hCAFE_0002;
        #2 areset = 1'b0;
        #1 check_reset_outs("rst_mid");
        mdl_err = 1'b0;
        @(posedge clk);
        @(negedge clk);
        areset = 1'b1;
        rdata_i = 32'hCAFE_0003;
        tick();
        check("rst_after_rrdy", 64'(rready_o), 64'd0);
        check("rst_after_status", 64'(status_o), 64'd0);
        rdata_i = 32'hCAFE_0004; rlast_i = 1'b1;
        tick();
        check("rst_after2_rrdy", 64'(rready_o), 64'd0);
        check("rst_after2_status", 64'(status_o), 64'd0);
        rvalid_i = 1'b0; rlast_i = 1'b0;
        run_burst(64'h8000, 1, 0, -1, -1, 0, 0, 0, 1'b0, 1'b0);
        readback();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
